// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the pipeline hazard controller
package hazard_pkg;

  // Controller state: free-running or holding the front end for bubbles
  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_t;

  // ALU operand source selects
  localparam logic [1:0] FWD_NONE = 2'b00;  // register file
  localparam logic [1:0] FWD_WB   = 2'b01;  // MEM/WB result
  localparam logic [1:0] FWD_MEM  = 2'b10;  // EX/MEM result

  // Bubble counts; with forwarding only a load feeding the next op stalls
  localparam logic [1:0] BUBBLES_NONE      = 2'd0;
  localparam logic [1:0] BUBBLES_LOAD_USE  = 2'd1;
  // Without forwarding the consumer waits until the producer has retired
  localparam logic [1:0] BUBBLES_NOFWD_EX  = 2'd3;
  localparam logic [1:0] BUBBLES_NOFWD_MEM = 2'd2;
  localparam logic [1:0] BUBBLES_NOFWD_WB  = 2'd1;

endpackage

// File: rtl/forward_unit.sv
// rtl/forward_unit.sv - ALU operand forwarding select (active only with HAZARD_FORWARD_EN)
module forward_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] ex_rs1,
  input  logic [REG_ADDR_W-1:0] ex_rs2,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_reg_write,
  input  logic                  mem_mem_read,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_reg_write,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b
);

`ifdef HAZARD_FORWARD_EN
  // Youngest producer wins; a load in EX/MEM has no data yet, so it is skipped
  function automatic logic [1:0] pick(input logic [REG_ADDR_W-1:0] rs);
    logic [1:0] sel;
    sel = FWD_NONE;
    if (mem_reg_write && !mem_mem_read && (mem_rd != '0) && (mem_rd == rs))
      sel = FWD_MEM;
    else if (wb_reg_write && (wb_rd != '0) && (wb_rd == rs))
      sel = FWD_WB;
    return sel;
  endfunction

  // Independent select per ALU operand
  always_comb begin
    fwd_a = pick(ex_rs1);
    fwd_b = pick(ex_rs2);
  end
`else
  // Forwarding compiled out: operands always come from the register file
  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{ex_rs1, ex_rs2, mem_rd, mem_reg_write,
                               mem_mem_read, wb_rd, wb_reg_write};

  // Constant register-file select
  always_comb begin
    fwd_a = FWD_NONE;
    fwd_b = FWD_NONE;
  end
`endif

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use/data stall, branch flush and forwarding control; HAZARD_FORWARD_EN enables forwarding
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rs1,
  input  logic [REG_ADDR_W-1:0] ex_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_reg_write,
  input  logic                  mem_mem_read,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_reg_write,
  input  logic                  ex_branch_taken,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  if_id_flush,
  output logic                  id_ex_bubble,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_count
);

  state_t     state, state_n;
  logic [1:0] stall_cnt, stall_cnt_n;
  logic [1:0] need;
  logic [1:0] fwd_a_raw, fwd_b_raw;

  // A producer matches only a source actually read, and never x0
  function automatic logic hit(input logic [REG_ADDR_W-1:0] rd,
                               input logic                  we,
                               input logic [REG_ADDR_W-1:0] rs,
                               input logic                  used);
    return used && we && (rd != '0) && (rd == rs);
  endfunction

  // Bubbles the instruction in IF/ID needs before it may enter ID/EX
  always_comb begin
    need = BUBBLES_NONE;
`ifdef HAZARD_FORWARD_EN
    if (ex_mem_read && (hit(ex_rd, ex_reg_write, id_rs1, id_uses_rs1) ||
                        hit(ex_rd, ex_reg_write, id_rs2, id_uses_rs2)))
      need = BUBBLES_LOAD_USE;
`else
    // Checked oldest to youngest so the nearest producer sets the maximum
    if (hit(wb_rd, wb_reg_write, id_rs1, id_uses_rs1) ||
        hit(wb_rd, wb_reg_write, id_rs2, id_uses_rs2))
      need = BUBBLES_NOFWD_WB;
    if (hit(mem_rd, mem_reg_write, id_rs1, id_uses_rs1) ||
        hit(mem_rd, mem_reg_write, id_rs2, id_uses_rs2))
      need = BUBBLES_NOFWD_MEM;
    if (hit(ex_rd, ex_reg_write, id_rs1, id_uses_rs1) ||
        hit(ex_rd, ex_reg_write, id_rs2, id_uses_rs2))
      need = BUBBLES_NOFWD_EX;
`endif
  end

`ifndef HAZARD_FORWARD_EN
  // Load flag only matters when forwarding can shorten the stall
  logic unused_load_flag;
  assign unused_load_flag = ex_mem_read;
`endif

  forward_unit #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_forward_unit (
    .ex_rs1        (ex_rs1),
    .ex_rs2        (ex_rs2),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .mem_mem_read  (mem_mem_read),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .fwd_a         (fwd_a_raw),
    .fwd_b         (fwd_b_raw)
  );

  // Selects are held at the register file while reset is asserted
  assign fwd_a = reset ? fwd_a_raw : FWD_NONE;
  assign fwd_b = reset ? fwd_b_raw : FWD_NONE;

  // State and remaining-bubble register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_RUN;
      stall_cnt <= 2'd0;
    end else begin
      state     <= state_n;
      stall_cnt <= stall_cnt_n;
    end
  end

  // Next state and pipeline enables; reset forces the idle pattern at once
  always_comb begin
    state_n      = state;
    stall_cnt_n  = stall_cnt;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    case (state)
      ST_RUN: begin
        if (ex_branch_taken) begin
          // Wrong-path instructions die; the redirect must still load the PC
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
        end else if (need != BUBBLES_NONE) begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
          stall_cnt_n  = need - 2'd1;
          state_n      = (need > 2'd1) ? ST_STALL : ST_RUN;
        end
      end
      ST_STALL: begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b1;
        stall_cnt_n  = stall_cnt - 2'd1;
        if (stall_cnt <= 2'd1) state_n = ST_RUN;
      end
      default: begin
        state_n     = ST_RUN;
        stall_cnt_n = 2'd0;
      end
    endcase
    if (!reset) begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
    end
  end

  // Saturating stall and flush event counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (id_ex_bubble && !if_id_flush && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 1'b1;
      if (if_id_flush && (flush_count != '1))
        flush_count <= flush_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - randomized and directed check of hazard_ctrl against a bubble-count model
module tb_hazard_ctrl;

  localparam int AW      = 5;
  localparam int CW      = 5;
  localparam int CNT_MAX = (1 << CW) - 1;
`ifdef HAZARD_FORWARD_EN
  localparam int EXP_LU    = 1;
  localparam int EXP_EXALU = 0;
`else
  localparam int EXP_LU    = 3;
  localparam int EXP_EXALU = 3;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic          id_uses_rs1, id_uses_rs2, ex_reg_write, ex_mem_read;
  logic          mem_reg_write, mem_mem_read, wb_reg_write, ex_branch_taken;
  logic          pc_write, if_id_write, if_id_flush, id_ex_bubble;
  logic [1:0]    fwd_a, fwd_b;
  logic [CW-1:0] stall_cycles, flush_count;

  int checks = 0;
  int errors = 0;

  // Model: bubbles still owed, and the two event counts
  int m_rem = 0;
  int m_stall = 0;
  int m_flush = 0;
  int e_rem_n;
  logic e_pc, e_ifid, e_flush, e_bub;

  hazard_ctrl #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .mem_mem_read(mem_mem_read), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .ex_branch_taken(ex_branch_taken), .pc_write(pc_write), .if_id_write(if_id_write),
    .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit match(input int rd, input bit we, input int rs, input bit used);
    return used && we && rd != 0 && rd == rs;
  endfunction

  // Bubbles demanded by the instruction in IF/ID, max over both sources
  function automatic int model_need();
    int n, srcs[2];
    bit used[2];
    n = 0;
    srcs[0] = id_rs1; srcs[1] = id_rs2;
    used[0] = id_uses_rs1; used[1] = id_uses_rs2;
    for (int s = 0; s < 2; s++) begin
`ifdef HAZARD_FORWARD_EN
      if (ex_mem_read && match(ex_rd, ex_reg_write, srcs[s], used[s])) n = (n > 1) ? n : 1;
`else
      if (match(ex_rd, ex_reg_write, srcs[s], used[s]))   n = (n > 3) ? n : 3;
      if (match(mem_rd, mem_reg_write, srcs[s], used[s])) n = (n > 2) ? n : 2;
      if (match(wb_rd, wb_reg_write, srcs[s], used[s]))   n = (n > 1) ? n : 1;
`endif
    end
    return n;
  endfunction

  function automatic logic [1:0] model_fwd(input int rs);
`ifdef HAZARD_FORWARD_EN
    if (mem_reg_write && !mem_mem_read && mem_rd != 0 && mem_rd == rs) return 2'b10;
    if (wb_reg_write && wb_rd != 0 && wb_rd == rs) return 2'b01;
`endif
    return 2'b00;
  endfunction

  task automatic clear_inputs();
    {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
    {id_uses_rs1, id_uses_rs2, ex_reg_write, ex_mem_read} = '0;
    {mem_reg_write, mem_mem_read, wb_reg_write, ex_branch_taken} = '0;
  endtask

  task automatic random_inputs();
    id_rs1 = AW'($urandom_range(0, 3)); id_rs2 = AW'($urandom_range(0, 3));
    ex_rs1 = AW'($urandom_range(0, 3)); ex_rs2 = AW'($urandom_range(0, 3));
    ex_rd  = AW'($urandom_range(0, 3)); mem_rd = AW'($urandom_range(0, 3));
    wb_rd  = AW'($urandom_range(0, 3));
    id_uses_rs1   = 1'($urandom_range(0, 1)); id_uses_rs2 = 1'($urandom_range(0, 1));
    ex_reg_write  = ($urandom_range(0, 3) != 0); ex_mem_read = 1'($urandom_range(0, 1));
    mem_reg_write = ($urandom_range(0, 3) != 0); mem_mem_read = 1'($urandom_range(0, 1));
    wb_reg_write  = ($urandom_range(0, 3) != 0);
    ex_branch_taken = ($urandom_range(0, 7) == 0);
  endtask

  // One clock with inputs already applied just after a falling edge
  task automatic drive_cycle();
    int n;
    #1;
    e_pc = 1; e_ifid = 1; e_flush = 0; e_bub = 0; e_rem_n = 0;
    if (m_rem > 0) begin
      e_pc = 0; e_ifid = 0; e_bub = 1; e_rem_n = m_rem - 1;
    end else if (ex_branch_taken) begin
      e_flush = 1; e_bub = 1;
    end else begin
      n = model_need();
      if (n > 0) begin
        e_pc = 0; e_ifid = 0; e_bub = 1; e_rem_n = n - 1;
      end
    end
    check("pc_write", 32'(pc_write), 32'(e_pc));
    check("if_id_write", 32'(if_id_write), 32'(e_ifid));
    check("if_id_flush", 32'(if_id_flush), 32'(e_flush));
    check("id_ex_bubble", 32'(id_ex_bubble), 32'(e_bub));
    check("fwd_a", 32'(fwd_a), 32'(model_fwd(ex_rs1)));
    check("fwd_b", 32'(fwd_b), 32'(model_fwd(ex_rs2)));
    @(posedge clk);
    if (e_bub && !e_flush && m_stall < CNT_MAX) m_stall++;
    if (e_flush && m_flush < CNT_MAX) m_flush++;
    m_rem = e_rem_n;
    #1;
    check("stall_cycles", 32'(stall_cycles), 32'(m_stall));
    check("flush_count", 32'(flush_count), 32'(m_flush));
    @(negedge clk);
  endtask

  // Asynchronous reset with immediate output check; returns at a falling edge
  task automatic do_reset();
    reset = 1'b0;
    #1;
    check("rst_pc_write", 32'(pc_write), 32'd1);
    check("rst_if_id_write", 32'(if_id_write), 32'd1);
    check("rst_if_id_flush", 32'(if_id_flush), 32'd0);
    check("rst_id_ex_bubble", 32'(id_ex_bubble), 32'd0);
    check("rst_fwd", 32'({fwd_a, fwd_b}), 32'd0);
    check("rst_counters", 32'({stall_cycles, flush_count}), 32'd0);
    m_rem = 0; m_stall = 0; m_flush = 0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    clear_inputs();
    // Producers present during reset must not leak through
    ex_reg_write = 1; ex_rd = 5; id_rs1 = 5; id_uses_rs1 = 1; ex_branch_taken = 1;
    mem_reg_write = 1; mem_rd = 2; ex_rs1 = 2; wb_reg_write = 1; wb_rd = 3; ex_rs2 = 3;
    do_reset();
    clear_inputs();
    drive_cycle();

    // Load in EX feeding rs1 of the next instruction
    ex_mem_read = 1; ex_reg_write = 1; ex_rd = 5; id_rs1 = 5; id_uses_rs1 = 1;
    drive_cycle();
    clear_inputs();
    repeat (3) drive_cycle();
    check("lu_stall_cycles", 32'(stall_cycles), 32'(EXP_LU));

    // EX/MEM producer for ALU operand b, then also in MEM/WB, then x0
    mem_reg_write = 1; mem_rd = 6; ex_rs2 = 6;
    drive_cycle();
    wb_reg_write = 1; wb_rd = 6;
    drive_cycle();
    mem_rd = 0; wb_rd = 0;
    drive_cycle();
    clear_inputs();

    // Branch wins over a simultaneous load-use match
    do_reset();
    ex_mem_read = 1; ex_reg_write = 1; ex_rd = 5; id_rs1 = 5; id_uses_rs1 = 1;
    ex_branch_taken = 1;
    drive_cycle();
    clear_inputs();
    check("br_flush_count", 32'(flush_count), 32'd1);
    check("br_stall_cycles", 32'(stall_cycles), 32'd0);

    // ALU producer in ID/EX on rs2
    do_reset();
    ex_reg_write = 1; ex_rd = 7; id_rs2 = 7; id_uses_rs2 = 1; ex_rs1 = 7; ex_rs2 = 7;
    drive_cycle();
    clear_inputs();
    repeat (3) drive_cycle();
    check("ex_stall_cycles", 32'(stall_cycles), 32'(EXP_EXALU));

    // Reset during the second stall cycle; branch in STALL must be ignored
    do_reset();
    ex_reg_write = 1; ex_mem_read = 1; ex_rd = 4; id_rs1 = 4; id_uses_rs1 = 1;
    drive_cycle();
    clear_inputs();
    ex_branch_taken = 1;
    #2;
    do_reset();
    clear_inputs();
    drive_cycle();
    check("post_rst_stall_cycles", 32'(stall_cycles), 32'd0);

    // Saturation of the stall counter
    ex_reg_write = 1; ex_mem_read = 1; ex_rd = 3; id_rs2 = 3; id_uses_rs2 = 1;
    repeat (CNT_MAX + 2) drive_cycle();
    check("sat_stall_cycles", 32'(stall_cycles), 32'(CNT_MAX));
    clear_inputs();

    // Randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      random_inputs();
      drive_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_ADDR_W, default 5, register-address width.
REQ-002 SHALL have parameter CNT_W, default 32, performance-counter width.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports id_rs1, id_rs2  input  REG_ADDR_W  source registers of instruction in IF/ID.
REQ-006 SHALL have ports id_uses_rs1, id_uses_rs2  input  1  source actually read.
REQ-007 SHALL have ports ex_rs1, ex_rs2  input  REG_ADDR_W  sources of instruction in ID/EX.
REQ-008 SHALL have ports ex_rd, ex_reg_write, ex_mem_read  input  REG_ADDR_W/1/1  ID/EX producer.
REQ-009 SHALL have ports mem_rd, mem_reg_write, mem_mem_read  input  REG_ADDR_W/1/1  EX/MEM producer.
REQ-010 SHALL have ports wb_rd, wb_reg_write  input  REG_ADDR_W/1  MEM/WB producer.
REQ-011 SHALL have port ex_branch_taken  input  1  branch resolved taken in EX.
REQ-012 SHALL have ports pc_write, if_id_write  output  1  PC and IF/ID enables.
REQ-013 SHALL have ports if_id_flush, id_ex_bubble  output  1  zero IF/ID; insert NOP into ID/EX.
REQ-014 SHALL have ports fwd_a, fwd_b  output  2  ALU operand select: 00 regfile, 01 MEM/WB, 10 EX/MEM.
REQ-015 SHALL have ports stall_cycles, flush_count  output  CNT_W  saturating performance counters.

Function
REQ-016 SHALL implement FSM states RUN and STALL plus down-counter stall_cnt (2 bits).
REQ-017 A match SHALL require producer reg_write=1, rd!=0, rd equal to a used id_rs; x0 never matches.
REQ-018 Required bubbles N (with forwarding): 1 if ID/EX match with ex_mem_read=1, else 0; max over rs1/rs2.
REQ-019 In RUN with N>0: pc_write=0, if_id_write=0, id_ex_bubble=1 same cycle (combinational); stall_cnt<=N-1; next state STALL if N-1>0 else RUN.
REQ-020 In STALL: pc_write=0, if_id_write=0, id_ex_bubble=1; stall_cnt decrements; at stall_cnt==1 next state RUN; no new detection.
REQ-021 ex_branch_taken=1 in RUN SHALL assert if_id_flush=1, id_ex_bubble=1, pc_write=1, and override any load-use stall that cycle.
REQ-022 ex_branch_taken in STALL SHALL be ignored.
REQ-023 fwd_a SHALL be 10 when mem_reg_write, mem_mem_read=0, mem_rd!=0, mem_rd==ex_rs1; else 01 when wb_reg_write, wb_rd!=0, wb_rd==ex_rs1; else 00; fwd_b identical for ex_rs2.
REQ-024 stall_cycles SHALL increment each cycle id_ex_bubble=1 without if_id_flush; flush_count each flush; both saturate at all-ones.
REQ-025 Idle (no hazard, RUN): pc_write=1, if_id_write=1, if_id_flush=0, id_ex_bubble=0.

Reset
REQ-026 reset=0 SHALL immediately force state RUN, stall_cnt=0, counters=0, pc_write=1, if_id_write=1, if_id_flush=0, id_ex_bubble=0, fwd_a=fwd_b=00.
REQ-027 Reset asserted mid-STALL SHALL abandon the stall; first cycle after release is RUN.

Configuration
REQ-028 Macro HAZARD_FORWARD_EN SHALL select forwarding.
REQ-029 Defined: REQ-018 and REQ-023 apply as written.
REQ-030 Undefined: fwd_a=fwd_b=00 always; N=3 for ID/EX match, 2 for EX/MEM match, 1 for MEM/WB match (regfile has no write-through), max over sources.

Structure
REQ-031 Package hazard_pkg SHALL hold the state enum, FWD_NONE/FWD_WB/FWD_MEM constants and bubble-count constants.
REQ-032 Forwarding selection SHALL be sub-module forward_unit (combinational), instantiated once.

Verification
REQ-033 lw x5 in EX (ex_mem_read=1, ex_rd=5), id_rs1=5, forwarding -> one cycle pc_write=0, id_ex_bubble=1, then RUN; stall_cycles=1.
REQ-034 add x6 in EX/MEM, ex_rs2=6 -> fwd_b=10; same rd also in MEM/WB -> still 10; rd=0 -> 00.
REQ-035 ex_branch_taken=1 concurrent with load-use match -> if_id_flush=1, pc_write=1, flush_count=1, stall_cycles=0.
REQ-036 No HAZARD_FORWARD_EN, ID/EX producer rd=7, id_rs2=7 -> 3 consecutive bubble cycles, fwd 00 throughout.
REQ-037 reset=0 during second STALL cycle -> outputs at reset values immediately; after release idle RUN, counters 0.
REQ-038 Force stall_cycles to all-ones, one more stall -> value unchanged.
